// File: rtl/watchdog_mc.sv
// Multi-channel watchdog: CH down-counting timers sharing one programmable prescaler.
// Each channel is periodic or one-shot, can be kicked, and owns a sticky expiry flag.
module watchdog_mc #(
   parameter int unsigned N  = 12,
   parameter int unsigned CH = 4,
   parameter int unsigned PW = 8,
   localparam int unsigned SW = $clog2(CH)
) (
   input  logic          i_clk_p,
   input  logic          i_rst_p,
   input  logic          i_we,
   input  logic [SW-1:0] i_ch_sel,
   input  logic [N-1:0]  i_cycles,
   input  logic          i_mode,
   input  logic          i_presc_we,
   input  logic [PW-1:0] i_presc,
   input  logic [CH-1:0] i_kick,
   input  logic [CH-1:0] i_clr,
   output logic [CH-1:0] o_inter,
   output logic [CH-1:0] o_flag,
   output logic          o_irq,
   output logic [CH-1:0] o_active
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRun     = 2'd1,
      StExpired = 2'd2
   } state_e;

   state_e        state_q  [CH];
   state_e        state_d  [CH];
   logic [N-1:0]  count_q  [CH];
   logic [N-1:0]  count_d  [CH];
   logic [N-1:0]  reload_q [CH];
   logic [N-1:0]  reload_d [CH];
   logic [CH-1:0] mode_q, mode_d;
   logic [CH-1:0] inter_q, inter_d;
   logic [CH-1:0] flag_q, flag_d;
   logic [CH-1:0] active_q, active_d;
   logic [CH-1:0] expire;
   logic          irq_q, irq_d;
   logic [PW-1:0] pc_q, pc_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   // Shared prescaler: a divisor write restarts the phase and suppresses the tick.
   always_comb begin
      tick    = (pc_q == presc_q) && !i_presc_we;
      presc_d = i_presc_we ? i_presc : presc_q;
      if (i_presc_we || tick) begin
         pc_d = '0;
      end else begin
         pc_d = pc_q + 1'b1;
      end
   end

   // Per-channel next state; write beats kick beats tick, so either one masks an expiry.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      expire   = '0;
      for (int k = 0; k < CH; k++) begin
         if (i_we && (i_ch_sel == SW'(k))) begin
            reload_d[k] = i_cycles;
            count_d[k]  = i_cycles;
            mode_d[k]   = i_mode;
            state_d[k]  = (i_cycles != '0) ? StRun : StIdle;
         end else if (i_kick[k] && (state_q[k] != StIdle)) begin
            count_d[k] = reload_q[k];
            state_d[k] = StRun;
         end else if ((state_q[k] == StRun) && tick) begin
            if (count_q[k] != '0) begin
               count_d[k] = count_q[k] - 1'b1;
            end else begin
               expire[k] = 1'b1;
               if (mode_q[k]) begin
                  state_d[k] = StExpired;
               end else begin
                  count_d[k] = reload_q[k];
               end
            end
         end
      end
   end

   // Output next state; an expiry outranks a flag clear in the same cycle.
   always_comb begin
      inter_d  = expire;
      flag_d   = expire | (flag_q & ~i_clr);
      irq_d    = |flag_q;
      active_d = '0;
      for (int k = 0; k < CH; k++) begin
         active_d[k] = (state_d[k] == StRun);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk_p) begin
      if (i_rst_p) begin
         for (int k = 0; k < CH; k++) begin
            state_q[k]  <= StIdle;
            count_q[k]  <= '0;
            reload_q[k] <= '0;
         end
         mode_q   <= '0;
         inter_q  <= '0;
         flag_q   <= '0;
         active_q <= '0;
         irq_q    <= 1'b0;
         pc_q     <= '0;
         presc_q  <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         inter_q  <= inter_d;
         flag_q   <= flag_d;
         active_q <= active_d;
         irq_q    <= irq_d;
         pc_q     <= pc_d;
         presc_q  <= presc_d;
      end
   end

   assign o_inter  = inter_q;
   assign o_flag   = flag_q;
   assign o_irq    = irq_q;
   assign o_active = active_q;

endmodule
